// File: rtl/md_ctrl_if.sv
// md_ctrl_if: bundles the E-stage issue, D-stage hazard and HI/LO read signals
// of the multiply/divide controller. The master side is the pipeline, the
// slave side is md_ctrl.
interface md_ctrl_if;
    logic        start;    // E-stage MD instruction valid
    logic [3:0]  mdOp;     // operation code
    logic [31:0] srcA;     // GPR[rs] after forwarding
    logic [31:0] srcB;     // GPR[rt] after forwarding
    logic        dIsMd;    // D-stage instruction is an MD op
    logic        busy;     // multi-cycle operation in progress
    logic        stallMd;  // MD-class stall request to the hazard unit
    logic [31:0] mdOut;    // mfhi/mflo read data
    logic [31:0] hi;       // current HI
    logic [31:0] lo;       // current LO

    modport master (
        output start, mdOp, srcA, srcB, dIsMd,
        input  busy, stallMd, mdOut, hi, lo
    );

    modport slave (
        input  start, mdOp, srcA, srcB, dIsMd,
        output busy, stallMd, mdOut, hi, lo
    );
endinterface

// File: rtl/md_ctrl.sv
// md_ctrl: HI/LO owner and multi-cycle mult/multu/div/divu sequencer.
// The result is computed combinationally at the start edge and held as a
// pending value; busy is held for a fixed latency, after which the pending
// value is committed to HI/LO.
// Optional feature macro: MD_CTRL_MADD_EN (enables mdOp 9, signed madd).
module md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic    clk,
    input  logic    rst_n,
    md_ctrl_if.slave md
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [3:0] MULT_LAT_M1 = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LAT_M1  = 4'(DIV_CYCLES - 1);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] phi_q, plo_q;
    logic        busy_q;

    logic        long_d;      // current op is a multi-cycle op
    logic [3:0]  lat_m1_d;    // latency minus one for the current op
    logic [63:0] res_d;       // {hi,lo} the current op will commit

    logic signed [63:0] a_s64, b_s64, prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] divisor;
    logic signed [31:0] quot_s, rem_s;
    logic        [31:0] quot_u, rem_u;
    logic               div_ovf;

    assign a_s64   = {{32{md.srcA[31]}}, md.srcA};
    assign b_s64   = {{32{md.srcB[31]}}, md.srcB};
    assign prod_s  = a_s64 * b_s64;
    assign prod_u  = {32'd0, md.srcA} * {32'd0, md.srcB};
    // A zero divisor is replaced so the dividers never see it; the result is
    // discarded in that case anyway.
    assign divisor = (md.srcB == 32'd0) ? 32'd1 : md.srcB;
    assign quot_s  = $signed(md.srcA) / $signed(divisor);
    assign rem_s   = $signed(md.srcA) % $signed(divisor);
    assign quot_u  = md.srcA / divisor;
    assign rem_u   = md.srcA % divisor;
    // The one signed quotient that does not fit in 32 bits wraps to itself.
    assign div_ovf = (md.srcA == 32'h8000_0000) && (md.srcB == 32'hFFFF_FFFF);

    // Select the pending result and latency for the op currently in E.
    always_comb begin
        long_d   = 1'b0;
        lat_m1_d = 4'd0;
        res_d    = {hi_q, lo_q};
        case (md.mdOp)
            4'd1: begin
                long_d   = 1'b1;
                lat_m1_d = MULT_LAT_M1;
                res_d    = prod_s;
            end
            4'd2: begin
                long_d   = 1'b1;
                lat_m1_d = MULT_LAT_M1;
                res_d    = prod_u;
            end
            4'd3: begin
                long_d   = 1'b1;
                lat_m1_d = DIV_LAT_M1;
                if (md.srcB == 32'd0)
                    res_d = {hi_q, lo_q};
                else if (div_ovf)
                    res_d = {32'd0, 32'h8000_0000};
                else
                    res_d = {rem_s, quot_s};
            end
            4'd4: begin
                long_d   = 1'b1;
                lat_m1_d = DIV_LAT_M1;
                if (md.srcB == 32'd0)
                    res_d = {hi_q, lo_q};
                else
                    res_d = {rem_u, quot_u};
            end
`ifdef MD_CTRL_MADD_EN
            4'd9: begin
                long_d   = 1'b1;
                lat_m1_d = MULT_LAT_M1;
                res_d    = {hi_q, lo_q} + prod_s;
            end
`else
`endif
            default: ;
        endcase
    end

    // IDLE/BUSY sequencer, HI/LO writes and registered busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            phi_q   <= 32'd0;
            plo_q   <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (md.start && long_d) begin
                        phi_q   <= res_d[63:32];
                        plo_q   <= res_d[31:0];
                        cnt_q   <= lat_m1_d;
                        state_q <= BUSY;
                        busy_q  <= 1'b1;
                    end else if (md.start && md.mdOp == 4'd5) begin
                        hi_q <= md.srcA;
                    end else if (md.start && md.mdOp == 4'd6) begin
                        lo_q <= md.srcA;
                    end
                end
                BUSY: begin
                    if (cnt_q == 4'd0) begin
                        hi_q    <= phi_q;
                        lo_q    <= plo_q;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign md.busy    = busy_q;
    assign md.stallMd = md.dIsMd & (md.start | busy_q);
    assign md.mdOut   = (md.mdOp == 4'd7) ? hi_q :
                        (md.mdOp == 4'd8) ? lo_q : 32'd0;
    assign md.hi      = hi_q;
    assign md.lo      = lo_q;
endmodule
